// File: rtl/adjacent_count_scheduler.sv
// rtl/adjacent_count_scheduler.sv - arbitrates clear / neighbour-increment / cell-read traffic onto the single-port number board
module adjacent_count_scheduler #(
    parameter  int BOARD_W = 8,
    parameter  int BOARD_H = 8,
    parameter  int CNT_W   = 4,
    localparam int XW      = $clog2(BOARD_W),
    localparam int YW      = $clog2(BOARD_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_req_i,
    output logic             clr_ack_o,
    output logic             clr_done_o,
    input  logic             inc_req_i,
    input  logic [XW-1:0]    inc_x_i,
    input  logic [YW-1:0]    inc_y_i,
    output logic             inc_ack_o,
    output logic             inc_done_o,
    input  logic             rd_req_i,
    input  logic [XW-1:0]    rd_x_i,
    input  logic [YW-1:0]    rd_y_i,
    output logic             rd_gnt_o,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             busy_o,
    output logic             ovf_o,
    output logic [XW-1:0]    mem_x_o,
    output logic [YW-1:0]    mem_y_o,
    output logic             mem_we_o,
    output logic [CNT_W-1:0] mem_wdata_o,
    input  logic [CNT_W-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE, CLR, N_CHK, N_RD, N_WR, INC_DONE, R_ADDR, R_DATA
    } state_t;

    localparam logic [XW:0]   W_LIM = (XW+1)'(BOARD_W);
    localparam logic [YW:0]   H_LIM = (YW+1)'(BOARD_H);
    localparam logic [XW-1:0] X_MAX = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(BOARD_H - 1);

    state_t         state_q, state_d;
    logic [2:0]     k_q, k_d;
    logic [XW-1:0]  cx_q, cx_d, rx_q, rx_d, clx_q, clx_d;
    logic [YW-1:0]  cy_q, cy_d, ry_q, ry_d, cly_q, cly_d;
    logic           ovf_q, ovf_d;

    logic [XW:0]    dx, nx;
    logic [YW:0]    dy, ny;
    logic           oob;

    // Neighbour offsets in raster order around the centre; the extra top bit
    // makes a -1 step from column/row 0 land above the board limit.
    always_comb begin
        dx = '0;
        dy = '0;
        case (k_q)
            3'd0, 3'd3, 3'd5: dx = '1;
            3'd2, 3'd4, 3'd7: dx = (XW+1)'(1);
            default:          dx = '0;
        endcase
        case (k_q)
            3'd0, 3'd1, 3'd2: dy = '1;
            3'd5, 3'd6, 3'd7: dy = (YW+1)'(1);
            default:          dy = '0;
        endcase
        nx  = {1'b0, cx_q} + dx;
        ny  = {1'b0, cy_q} + dy;
        oob = (nx >= W_LIM) || (ny >= H_LIM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            clx_q   <= '0;
            cly_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            clx_q   <= clx_d;
            cly_q   <= cly_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        clx_d       = clx_q;
        cly_d       = cly_q;
        ovf_d       = ovf_q;
        clr_ack_o   = 1'b0;
        clr_done_o  = 1'b0;
        inc_ack_o   = 1'b0;
        inc_done_o  = 1'b0;
        rd_gnt_o    = 1'b0;
        rd_valid_o  = 1'b0;
        rd_data_o   = '0;
        mem_x_o     = '0;
        mem_y_o     = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        busy_o      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLR;
                    clx_d   = '0;
                    cly_d   = '0;
                    ovf_d   = 1'b0;
                end else if (inc_req_i) begin
                    state_d = N_CHK;
                    k_d     = '0;
                    cx_d    = inc_x_i;
                    cy_d    = inc_y_i;
                end else if (rd_req_i) begin
                    state_d = R_ADDR;
                    rx_d    = rd_x_i;
                    ry_d    = rd_y_i;
                end
            end
            CLR: begin
                mem_we_o  = 1'b1;
                mem_x_o   = clx_q;
                mem_y_o   = cly_q;
                clr_ack_o = (clx_q == '0) && (cly_q == '0);
                if ((clx_q == X_MAX) && (cly_q == Y_MAX)) begin
                    clr_done_o = 1'b1;
                    state_d    = IDLE;
                end else if (clx_q == X_MAX) begin
                    clx_d = '0;
                    cly_d = cly_q + 1'b1;
                end else begin
                    clx_d = clx_q + 1'b1;
                end
            end
            N_CHK: begin
                // k is only zero here on the first check of a request.
                inc_ack_o = (k_q == 3'd0);
                if (!oob) begin
                    state_d = N_RD;
                end else if (k_q == 3'd7) begin
                    state_d = INC_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            N_RD: begin
                mem_x_o = nx[XW-1:0];
                mem_y_o = ny[YW-1:0];
                state_d = N_WR;
            end
            N_WR: begin
                mem_we_o = 1'b1;
                mem_x_o  = nx[XW-1:0];
                mem_y_o  = ny[YW-1:0];
                if (&mem_rdata_i) begin
                    mem_wdata_o = mem_rdata_i;
                    ovf_d       = 1'b1;
                end else begin
                    mem_wdata_o = mem_rdata_i + 1'b1;
                end
                if (k_q == 3'd7) begin
                    state_d = INC_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = N_CHK;
                end
            end
            INC_DONE: begin
                inc_done_o = 1'b1;
                k_d        = '0;
                state_d    = IDLE;
            end
            R_ADDR: begin
                rd_gnt_o = 1'b1;
                mem_x_o  = rx_q;
                mem_y_o  = ry_q;
                state_d  = R_DATA;
            end
            R_DATA: begin
                rd_valid_o = 1'b1;
                rd_data_o  = mem_rdata_i;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_adjacent_count_scheduler.sv
// tb/tb_adjacent_count_scheduler.sv - directed and random checks of the number-board scheduler against a board model
module tb_adjacent_count_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr_req = 1'b0, clr_ack, clr_done;
    logic       inc_req = 1'b0, inc_ack, inc_done;
    logic [2:0] inc_x = '0, inc_y = '0;
    logic       rd_req = 1'b0, rd_gnt, rd_valid;
    logic [2:0] rd_x = '0, rd_y = '0;
    logic [3:0] rd_data;
    logic       busy, ovf;
    logic [2:0] mem_x, mem_y;
    logic       mem_we;
    logic [3:0] mem_wdata, mem_rdata;

    logic       pre_we = 1'b0;
    logic [2:0] pre_x = '0, pre_y = '0;
    logic [3:0] pre_d = '0;
    logic [3:0] ram [0:7][0:7];

    int board [0:7][0:7];
    bit ovf_m;
    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int x0_cnt = 0;

    adjacent_count_scheduler #(.BOARD_W(8), .BOARD_H(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .clr_req_i(clr_req), .clr_ack_o(clr_ack), .clr_done_o(clr_done),
        .inc_req_i(inc_req), .inc_x_i(inc_x), .inc_y_i(inc_y),
        .inc_ack_o(inc_ack), .inc_done_o(inc_done),
        .rd_req_i(rd_req), .rd_x_i(rd_x), .rd_y_i(rd_y),
        .rd_gnt_o(rd_gnt), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .busy_o(busy), .ovf_o(ovf),
        .mem_x_o(mem_x), .mem_y_o(mem_y), .mem_we_o(mem_we),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) ram[pre_y][pre_x] <= pre_d;
        else if (mem_we) ram[mem_y][mem_x] <= mem_wdata;
        mem_rdata <= ram[mem_y][mem_x];
    end

    always @(posedge clk) begin
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            if (mem_x == 3'd0) x0_cnt <= x0_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({clr_ack, clr_done, inc_ack, inc_done, rd_gnt, rd_valid, rd_data,
                    busy, ovf, mem_x, mem_y, mem_we, mem_wdata});
    endfunction

    // Applies an increment to the model, optionally only to the first 'limit' in-bound neighbours.
    task automatic model_inc(input int x, input int y, input int limit, output int inb);
        inb = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx == 0 && dy == 0) continue;
                if (x+dx < 0 || x+dx > 7 || y+dy < 0 || y+dy > 7) continue;
                if (inb < limit) begin
                    if (board[y+dy][x+dx] == 15) ovf_m = 1'b1;
                    else board[y+dy][x+dx]++;
                end
                inb++;
            end
    endtask

    task automatic do_clear();
        bit got = 0;
        int lat;
        clr_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (clr_ack) got = 1;
        end
        clr_req = 1'b0;
        chk("clr_ack_seen", 32'(got), 1);
        chk("busy_at_clr_ack", 32'(busy), 1);
        lat = 1;
        while (!clr_done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("clr_latency", lat, 64);
        for (int yy = 0; yy < 8; yy++)
            for (int xx = 0; xx < 8; xx++) board[yy][xx] = 0;
        ovf_m = 1'b0;
        @(negedge clk);
        chk("ovf_after_clr", 32'(ovf), 0);
        chk("idle_after_clr", 32'(busy), 0);
    endtask

    task automatic do_inc(input int x, input int y);
        bit got = 0;
        int lat, we0, inb;
        inc_x = 3'(x);
        inc_y = 3'(y);
        inc_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (inc_ack) got = 1;
        end
        inc_req = 1'b0;
        chk("inc_ack_seen", 32'(got), 1);
        we0 = we_cnt;
        lat = 1;
        while (!inc_done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        model_inc(x, y, 8, inb);
        chk("inc_latency", lat, 3*inb + (8-inb) + 1);
        chk("inc_writes", we_cnt - we0, inb);
        @(negedge clk);
        chk("ovf_after_inc", 32'(ovf), 32'(ovf_m));
    endtask

    task automatic do_read(input int x, input int y);
        bit got = 0;
        rd_x = 3'(x);
        rd_y = 3'(y);
        rd_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rd_gnt) got = 1;
        end
        rd_req = 1'b0;
        chk("rd_gnt_seen", 32'(got), 1);
        @(negedge clk);
        chk("rd_valid", 32'(rd_valid), 1);
        chk($sformatf("rd_data(%0d,%0d)", x, y), 32'(rd_data), board[y][x]);
        @(negedge clk);
    endtask

    task automatic check_all();
        for (int yy = 0; yy < 8; yy++)
            for (int xx = 0; xx < 8; xx++) do_read(xx, yy);
    endtask

    initial begin
        int x0s, ix, iy, rx, ry, n, inb, idle_cnt;
        int order [$];
        bit done;
        logic [3:0] rdv;

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outputs", all_outs(), 0);

        do_clear();
        do_read(0, 0);
        do_read(7, 7);

        do_inc(3, 3);
        check_all();

        do_clear();
        do_inc(0, 0);
        check_all();
        do_clear();
        x0s = x0_cnt;
        do_inc(7, 0);
        chk("no_wrap_x0_writes", x0_cnt - x0s, 0);
        check_all();

        // Simultaneous requests: expect clr, then inc, then rd with one idle cycle between each.
        ix = $urandom_range(0, 7);
        iy = $urandom_range(0, 7);
        rx = (ix == 7) ? 6 : ix + 1;
        ry = iy;
        inc_x = 3'(ix); inc_y = 3'(iy);
        rd_x = 3'(rx);  rd_y = 3'(ry);
        clr_req = 1'b1; inc_req = 1'b1; rd_req = 1'b1;
        idle_cnt = 0;
        done = 0;
        rdv = '0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (clr_ack) begin clr_req = 1'b0; order.push_back(1); end
            if (inc_ack) begin inc_req = 1'b0; order.push_back(2); end
            if (rd_gnt)  begin rd_req = 1'b0;  order.push_back(3); end
            if (!busy && order.size() > 0) idle_cnt++;
            if (rd_valid) begin done = 1; rdv = rd_data; end
        end
        clr_req = 1'b0; inc_req = 1'b0; rd_req = 1'b0;
        for (int yy = 0; yy < 8; yy++)
            for (int xx = 0; xx < 8; xx++) board[yy][xx] = 0;
        ovf_m = 1'b0;
        model_inc(ix, iy, 8, inb);
        chk("arb_count", order.size(), 3);
        chk("arb_first_clr", (order.size() > 0) ? order[0] : 0, 1);
        chk("arb_second_inc", (order.size() > 1) ? order[1] : 0, 2);
        chk("arb_third_rd", (order.size() > 2) ? order[2] : 0, 3);
        chk("arb_idle_gaps", idle_cnt, 2);
        chk("arb_rd_data", 32'(rdv), board[ry][rx]);
        @(negedge clk);

        // Saturation
        do_clear();
        pre_x = 3'd4; pre_y = 3'd4; pre_d = 4'd15; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
        board[4][4] = 15;
        do_inc(3, 3);
        chk("ovf_set", 32'(ovf), 1);
        check_all();
        do_clear();

        // Random increments
        for (int i = 0; i < 20; i++) do_inc($urandom_range(0, 7), $urandom_range(0, 7));
        check_all();

        // Reset during the write of neighbour 3 around (3,3)
        inc_x = 3'd3; inc_y = 3'd3; inc_req = 1'b1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (inc_ack) done = 1;
        end
        inc_req = 1'b0;
        chk("abort_inc_ack", 32'(done), 1);
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            if (mem_we) n++;
            if (n < 4) @(negedge clk);
        end
        chk("abort_reached_wr3", n, 4);
        reset = 1'b1;
        #1;
        chk("abort_outputs_zero", all_outs(), 0);
        model_inc(3, 3, 3, inb);
        ovf_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all();
        do_inc($urandom_range(0, 7), $urandom_range(0, 7));
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
